// File: rtl/pll_reset_seq_pkg.sv
// Shared types and helpers for the PLL reset/bring-up sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: sequencer state enum, counter widths, bypass/fault reset pulse
// length, registered-output bundle type, and small combinational helpers.
// Optional feature macro used elsewhere in the slice: PLL_RESET_SEQ_STATUS_EN.
package pll_seq_pkg;

  localparam int CNT_W     = 16;
  localparam int RTRY_W    = 4;
  // Cycles rst_out_n is held low after entering BYPASS or FAULT.
  localparam int BYP_PULSE = 2;

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABLE     = 3'd2,
    RUN        = 3'd3,
    BYPASS     = 3'd4,
    FAULT      = 3'd5
  } state_e;

  // Every pin the sequencer drives, registered together as one bundle.
  typedef struct packed {
    logic resetb;
    logic bypass;
    logic rst_n;
    logic locked;
    logic fault;
  } seq_out_t;

  // Saturating increment: the counter keeps running in BYPASS/FAULT, and a
  // wrap back to zero would re-open the rst_out_n low window.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  // Output pins as a function of the state being entered/held and the
  // counter value that goes with it. Evaluated on next-state values so the
  // registered pins line up with the registered state.
  function automatic seq_out_t outs_for(input state_e st, input logic [CNT_W-1:0] cnt);
    seq_out_t o;
    o = '0;
    case (st)
      WAIT_LOCK, STABLE: begin
        o.resetb = 1'b1;
      end
      RUN: begin
        o.resetb = 1'b1;
        o.rst_n  = 1'b1;
        o.locked = 1'b1;
      end
      BYPASS: begin
        o.bypass = 1'b1;
        o.rst_n  = (cnt >= CNT_W'(BYP_PULSE));
      end
      FAULT: begin
        o.bypass = 1'b1;
        o.fault  = 1'b1;
        o.rst_n  = (cnt >= CNT_W'(BYP_PULSE));
      end
      default: begin
        o = '0;
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pll_reset_seq_if.sv
// Pin bundle between the PLL reset sequencer and the PLL / downstream logic.
// Latency: n/a (wiring only).
// Backpressure: none; level signals, no handshake.
//
// Members: lock_in (PLL LOCK, async), bypass_req (sync request), pll_resetb,
// pll_bypass, rst_out_n, locked, fault, and loss_cnt[7:0] only when
// PLL_RESET_SEQ_STATUS_EN is defined.
// slave modport = sequencer side, master modport = PLL/system side.
interface pll_reset_seq_if;

  logic       lock_in;
  logic       bypass_req;
  logic       pll_resetb;
  logic       pll_bypass;
  logic       rst_out_n;
  logic       locked;
  logic       fault;
`ifdef PLL_RESET_SEQ_STATUS_EN
  logic [7:0] loss_cnt;
`endif

`ifdef PLL_RESET_SEQ_STATUS_EN
  modport slave (
    input  lock_in, bypass_req,
    output pll_resetb, pll_bypass, rst_out_n, locked, fault, loss_cnt
  );
  modport master (
    output lock_in, bypass_req,
    input  pll_resetb, pll_bypass, rst_out_n, locked, fault, loss_cnt
  );
`else
  modport slave (
    input  lock_in, bypass_req,
    output pll_resetb, pll_bypass, rst_out_n, locked, fault
  );
  modport master (
    output lock_in, bypass_req,
    input  pll_resetb, pll_bypass, rst_out_n, locked, fault
  );
`endif

endinterface

// File: rtl/pll_reset_seq_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
// Latency: q follows d after 2 clk edges.
// Backpressure: none.
//
// Ports: clk, reset (synchronous, active-low, clears both flops), d (async
// input), q (synchronized output).
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/pll_reset_seq.sv
// PLL bring-up sequencer: holds PLL in reset, waits for lock, qualifies it, releases rst_out_n.
// Latency: all pins registered; lock_in reaches the FSM 2 cycles late, state/pins change on the next edge.
// Backpressure: none; bypass_req is a level request and is ignored once in FAULT.
//
// Ports: clk (PLL reference clock), reset (synchronous, active-low),
// bus (pll_reset_seq_if.slave: lock_in, bypass_req in; pll_resetb,
// pll_bypass, rst_out_n, locked, fault out; loss_cnt out when
// PLL_RESET_SEQ_STATUS_EN is defined).
//
// Timing contract: cnt is 0 in the cycle a state is entered, so a state with
// a length parameter N is left on the edge where cnt reaches N-1 (N cycles
// spent). From reset release with lock already settled, pll_resetb rises on
// edge RESET_CYCLES and locked/rst_out_n rise on edge
// RESET_CYCLES + 1 + STABLE_CYCLES.
module pll_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3
) (
  input  logic            clk,
  input  logic            reset,
  pll_reset_seq_if.slave  bus
);

  // Last cnt value of each timed state (compare with >=, so 1 means 1 cycle).
  localparam logic [CNT_W-1:0]  RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RTRY_W-1:0] RTRY_MAX     = RTRY_W'(MAX_RETRIES);

  logic              lock_s;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RTRY_W-1:0] rtry_q, rtry_d;
  seq_out_t          out_q, out_d;

  sync2 u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.lock_in),
    .q     (lock_s)
  );

  // Next-state logic. Priority: bypass_req (outside FAULT) over lock
  // loss/timeout over count completion; reset is handled in the flops.
  always_comb begin
    state_d = state_q;
    rtry_d  = rtry_q;

    if (bus.bypass_req && (state_q != FAULT)) begin
      state_d = BYPASS;
    end else begin
      case (state_q)
        RESET_HOLD: begin
          if (cnt_q >= RESET_LAST) begin
            state_d = WAIT_LOCK;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABLE;
          end else if (cnt_q >= TIMEOUT_LAST) begin
            if (rtry_q == RTRY_MAX) begin
              state_d = FAULT;
            end else begin
              rtry_d  = rtry_q + RTRY_W'(1);
              state_d = RESET_HOLD;
            end
          end
        end
        STABLE: begin
          // A dropout goes back to waiting with a fresh timeout window; the
          // attempt number is kept so glitches alone never reach FAULT faster.
          if (!lock_s) begin
            state_d = WAIT_LOCK;
          end else if (cnt_q >= STABLE_LAST) begin
            state_d = RUN;
            rtry_d  = '0;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_d = RESET_HOLD;
          end
        end
        BYPASS: begin
          // Only reached with bypass_req low: restart bring-up from scratch.
          state_d = RESET_HOLD;
          rtry_d  = '0;
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = RESET_HOLD;
        end
      endcase
    end

    // One shared counter, reloaded on every state change.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_inc(cnt_q);
    end

    out_d = outs_for(state_d, cnt_d);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RESET_HOLD;
      cnt_q   <= '0;
      rtry_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rtry_q  <= rtry_d;
      out_q   <= out_d;
    end
  end

  assign bus.pll_resetb = out_q.resetb;
  assign bus.pll_bypass = out_q.bypass;
  assign bus.rst_out_n  = out_q.rst_n;
  assign bus.locked     = out_q.locked;
  assign bus.fault      = out_q.fault;

`ifdef PLL_RESET_SEQ_STATUS_EN
  // Count of lock losses while running; bypass does not clear it.
  logic [7:0] loss_cnt_q, loss_cnt_d;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if ((state_q == RUN) && (state_d == RESET_HOLD) && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_d = loss_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      loss_cnt_q <= '0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign bus.loss_cnt = loss_cnt_q;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed/randomized bench for pll_reset_seq against a timeline reference.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_pll_reset_seq;

  localparam int RC  = 16;
  localparam int LT  = 4096;
  localparam int SC  = 256;
  localparam int MR  = 3;
  localparam int ATT = RC + LT;          // one failed attempt, edges
  localparam int T_RUN = RC + 1 + SC;    // RESET_HOLD entry -> RUN with lock already settled
  localparam int T_FLT = (MR + 1) * ATT; // RESET_HOLD entry -> FAULT with no lock

  // {pll_resetb, pll_bypass, rst_out_n, locked, fault}
  localparam logic [4:0] V_HOLD = 5'b00000;
  localparam logic [4:0] V_WAIT = 5'b10000;
  localparam logic [4:0] V_RUN  = 5'b10110;
  localparam logic [4:0] V_BYP0 = 5'b01000;
  localparam logic [4:0] V_BYP  = 5'b01100;
  localparam logic [4:0] V_FLT0 = 5'b01001;
  localparam logic [4:0] V_FLT  = 5'b01101;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   edge_n   = 0;
  int   checks   = 0;
  int   failures = 0;

  pll_reset_seq_if bus ();

  pll_reset_seq #(
    .RESET_CYCLES  (RC),
    .LOCK_TIMEOUT  (LT),
    .STABLE_CYCLES (SC),
    .MAX_RETRIES   (MR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] obs();
    return {bus.pll_resetb, bus.pll_bypass, bus.rst_out_n, bus.locked, bus.fault};
  endfunction

  // Bring-up timeline with lock present, rel = edges since RESET_HOLD entry.
  function automatic logic [4:0] seq_exp(input int rel);
    if (rel < RC)    return V_HOLD;
    if (rel < T_RUN) return V_WAIT;
    return V_RUN;
  endfunction

  // Timeline with lock absent: MR+1 attempts of RC+LT, then FAULT with a
  // 2-edge rst_out_n low pulse.
  function automatic logic [4:0] att_exp(input int rel);
    if (rel < T_FLT) return ((rel % ATT) < RC) ? V_HOLD : V_WAIT;
    if (rel - T_FLT < 2) return V_FLT0;
    return V_FLT;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic chk(input string tag, input logic [4:0] exp);
    checks++;
    assert (obs() === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_n, obs(), exp);
    end
  endtask

`ifdef PLL_RESET_SEQ_STATUS_EN
  task automatic chk_loss(input string tag, input int exp);
    checks++;
    assert (bus.loss_cnt === 8'(exp)) else begin
      failures++;
      $error("FAIL %s loss_cnt observed=%0d expected=%0d", tag, bus.loss_cnt, exp);
    end
  endtask
`endif

  // Release reset with lock_in=1 and follow the whole bring-up into RUN.
  task automatic bringup(input string tag);
    reset       = 1'b1;
    bus.lock_in = 1'b1;
    for (int k = 1; k <= T_RUN + 6; k++) begin
      step();
      chk(tag, seq_exp(k));
    end
  endtask

  initial begin
    int w, l, off, g, l2, hb, b, r, fin;

    bus.lock_in    = 1'b0;
    bus.bypass_req = 1'b0;

    // Reset state.
    for (int k = 0; k < 3; k++) step();
    chk("reset_state", 5'b00000);
`ifdef PLL_RESET_SEQ_STATUS_EN
    chk_loss("reset_loss", 0);
`endif

    // Power-up bring-up with lock held high.
    bringup("bringup");

    // Lock dropout in RUN for a random 1..8 cycles: restart after 3 edges.
    w = $urandom_range(0, 20);
    for (int k = 0; k < w; k++) begin
      step();
      chk("run_idle", V_RUN);
    end
    l = $urandom_range(1, 8);
    bus.lock_in = 1'b0;
    for (int k = 1; k <= 3 + T_RUN + 4; k++) begin
      step();
      if (k == l) bus.lock_in = 1'b1;
      chk("run_drop", (k < 3) ? V_RUN : seq_exp(k - 3));
    end
`ifdef PLL_RESET_SEQ_STATUS_EN
    chk_loss("loss_one", 1);
`endif

    // Second dropout, then a glitch of 1..5 cycles while qualifying lock:
    // the stable count restarts after the glitch clears the synchronizer.
    off = $urandom_range(50, 200);
    g   = 3 + RC + 1 + off;
    l2  = $urandom_range(1, 5);
    bus.lock_in = 1'b0;
    for (int k = 1; k <= g + l2 + 3 + SC + 4; k++) begin
      step();
      if (k == 1) bus.lock_in = 1'b1;
      if (k == g) bus.lock_in = 1'b0;
      if (k == g + l2) bus.lock_in = 1'b1;
      if (k < 3)                chk("stable_glitch", V_RUN);
      else if (k < 3 + RC)      chk("stable_glitch", V_HOLD);
      else if (k < g + l2 + 3 + SC) chk("stable_glitch", V_WAIT);
      else                      chk("stable_glitch", V_RUN);
    end
`ifdef PLL_RESET_SEQ_STATUS_EN
    chk_loss("loss_two", 2);
`endif

    // Bypass requested from RUN, then released: full bring-up again.
    hb = $urandom_range(3, 20);
    bus.bypass_req = 1'b1;
    for (int k = 1; k <= hb + 1 + T_RUN + 4; k++) begin
      step();
      if (k == hb) bus.bypass_req = 1'b0;
      if (k <= 2)       chk("bypass_run", V_BYP0);
      else if (k <= hb) chk("bypass_run", V_BYP);
      else              chk("bypass_run", seq_exp(k - (hb + 1)));
    end
`ifdef PLL_RESET_SEQ_STATUS_EN
    chk_loss("loss_kept", 2);
`endif

    // Reset pulsed in RUN.
    reset       = 1'b0;
    bus.lock_in = 1'b0;
    step();
    chk("rst_in_run", 5'b00000);
`ifdef PLL_RESET_SEQ_STATUS_EN
    chk_loss("loss_cleared", 0);
`endif

    // No lock: one failed attempt, bypass during attempt 2, release; the
    // retry count must restart so FAULT needs MR+1 fresh attempts.
    reset = 1'b1;
    b   = ATT + RC + $urandom_range(0, 1000);
    hb  = $urandom_range(5, 30);
    r   = b + hb + 1;
    fin = r + T_FLT + 10;
    for (int k = 1; k <= fin; k++) begin
      step();
      if (k == b) bus.bypass_req = 1'b1;
      if (k == b + hb) bus.bypass_req = 1'b0;
      // bypass_req must be ignored once in FAULT
      if (k == r + T_FLT + 4) bus.bypass_req = 1'b1;
      if (k == r + T_FLT + 7) bus.bypass_req = 1'b0;
      if (k <= b)           chk("no_lock", att_exp(k));
      else if (k <= b + 2)  chk("bypass_wait", V_BYP0);
      else if (k <= b + hb) chk("bypass_wait", V_BYP);
      else                  chk("to_fault", att_exp(k - r));
    end

    // Reset pulsed in FAULT, then a clean bring-up.
    reset = 1'b0;
    step();
    chk("rst_in_fault", 5'b00000);
    bringup("rebringup");
`ifdef PLL_RESET_SEQ_STATUS_EN
    chk_loss("loss_final", 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
